// File: rtl/reconfig_req_seq.sv
// reconfig_req_seq: turns profile-change requests into one-shot reconfig strobes.
// Optional RECONF_PENDING_EN keeps one request received while busy.
module reconfig_req_seq #(
  parameter int NUM_PROFILES = 5,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] rate_sel,
  input  logic       rate_valid,
  input  logic [2:0] ctrl_state,
  input  logic       pll_locked,
  output logic       want_to_reconfig,
  output logic [2:0] intended_rom,
  output logic [2:0] active_rom,
  output logic       seq_busy,
  output logic       done,
  output logic       err_range,
  output logic       lock_err
);

  localparam logic [3:0]  NP  = 4'(NUM_PROFILES);
  localparam logic [15:0] TMO = 16'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_CTRL_IDLE,
    WAIT_LOCK
  } state_t;

  state_t      state;
  logic        lock_s1;
  logic        lock_s2;
  logic [15:0] cnt;
  logic        pend_v;
  logic [2:0]  pend_sel;
  logic        req_v;
  logic [2:0]  req_sel;
  logic        req_oor;
  logic        rate_oor;

  assign seq_busy = (state != IDLE);
  assign rate_oor = ({1'b0, rate_sel} >= NP);
  assign req_oor  = ({1'b0, req_sel} >= NP);

  // A live strobe takes precedence over a held request
  always_comb begin
    req_v   = rate_valid;
    req_sel = rate_sel;
    if (!rate_valid && pend_v) begin
      req_v   = 1'b1;
      req_sel = pend_sel;
    end
  end

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

`ifdef RECONF_PENDING_EN
  // Hold the latest in-range request seen while busy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_v   <= 1'b0;
      pend_sel <= 3'd0;
    end else if (state == IDLE) begin
      pend_v <= 1'b0;
    end else if (rate_valid && !rate_oor) begin
      pend_v   <= 1'b1;
      pend_sel <= rate_sel;
    end
  end
`else
  assign pend_v   = 1'b0;
  assign pend_sel = 3'd0;
`endif

  // Sequencer FSM with registered strobes and status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      want_to_reconfig <= 1'b0;
      intended_rom     <= 3'd0;
      active_rom       <= 3'd0;
      done             <= 1'b0;
      err_range        <= 1'b0;
      lock_err         <= 1'b0;
      cnt              <= 16'd0;
    end else begin
      want_to_reconfig <= 1'b0;
      done             <= 1'b0;
      err_range        <= rate_valid && rate_oor;
      case (state)
        IDLE: begin
          if (req_v && !req_oor) begin
            if (req_sel == active_rom) begin
              done <= 1'b1;
            end else begin
              intended_rom <= req_sel;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (ctrl_state == 3'd0) begin
            want_to_reconfig <= 1'b1;
            state            <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (ctrl_state != 3'd0) begin
            state <= WAIT_CTRL_IDLE;
          end
        end
        WAIT_CTRL_IDLE: begin
          if (ctrl_state == 3'd0) begin
            cnt   <= 16'd0;
            state <= WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (lock_s2) begin
            active_rom <= intended_rom;
            lock_err   <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else if (cnt == TMO) begin
            active_rom <= intended_rom;
            lock_err   <= 1'b1;
            done       <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reconfig_req_seq.sv
// tb_reconfig_req_seq: scoreboard bench with a transaction-level model
// and a behavioural downstream control/PLL emulator.
module tb_reconfig_req_seq;

  localparam int NP = 5;

  logic       clock;
  logic       reset_n;
  logic [2:0] rate_sel;
  logic       rate_valid;
  logic [2:0] ctrl_state;
  logic       pll_locked;
  logic       want_to_reconfig;
  logic [2:0] intended_rom;
  logic [2:0] active_rom;
  logic       seq_busy;
  logic       done;
  logic       err_range;
  logic       lock_err;

  reconfig_req_seq #(
    .NUM_PROFILES(NP),
    .LOCK_TIMEOUT(20)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rate_sel(rate_sel),
    .rate_valid(rate_valid),
    .ctrl_state(ctrl_state),
    .pll_locked(pll_locked),
    .want_to_reconfig(want_to_reconfig),
    .intended_rom(intended_rom),
    .active_rom(active_rom),
    .seq_busy(seq_busy),
    .done(done),
    .err_range(err_range),
    .lock_err(lock_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int want_q[$];
  int done_rom_q[$];
  int done_lerr_q[$];
  bit nolock_q[$];
  int err_cnt = 0;
  int m_active = 0;
  int m_lerr = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop expected events whenever the DUT presents one
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (want_to_reconfig) begin
        if (want_q.size() == 0) begin
          chk("unexpected_want", 1, 0);
        end else begin
          chk("want_rom", int'(intended_rom), want_q.pop_front());
        end
      end
      if (done) begin
        if (done_rom_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("done_active_rom", int'(active_rom), done_rom_q.pop_front());
          chk("done_lock_err", int'(lock_err), done_lerr_q.pop_front());
        end
      end
      if (err_range) begin
        chk("err_range_expected", int'(err_cnt > 0), 1);
        if (err_cnt > 0) err_cnt--;
      end
    end
  end

  // Downstream emulator: run the control FSM, then lock (or not)
  task automatic ctl_run();
    bit nl;
    nl = (nolock_q.size() > 0) ? nolock_q.pop_front() : 1'b0;
    pll_locked = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      @(negedge clock);
      if (!reset_n) return;
    end
    for (int v = 1; v <= 6; v++) begin
      ctrl_state = 3'(v);
      repeat (2) begin
        @(negedge clock);
        if (!reset_n) begin
          ctrl_state = 3'd0;
          return;
        end
      end
    end
    ctrl_state = 3'd0;
    if (!nl) begin
      repeat ($urandom_range(2, 8)) begin
        @(negedge clock);
        if (!reset_n) return;
      end
      pll_locked = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && want_to_reconfig === 1'b1) ctl_run();
    end
  end

  // Reference model: outcome of a request seen while idle
  task automatic model_idle(int sel, bit nl);
    if (sel >= NP) begin
      err_cnt++;
    end else if (sel == m_active) begin
      done_rom_q.push_back(m_active);
      done_lerr_q.push_back(m_lerr);
    end else begin
      want_q.push_back(sel);
      nolock_q.push_back(nl);
      m_active = sel;
      m_lerr = nl ? 1 : 0;
      done_rom_q.push_back(m_active);
      done_lerr_q.push_back(m_lerr);
    end
  endtask

  task automatic send(int sel);
    @(negedge clock);
    rate_sel = 3'(sel);
    rate_valid = 1'b1;
    @(negedge clock);
    rate_valid = 1'b0;
  endtask

  task automatic wait_ctrl();
    int n = 0;
    while (ctrl_state == 3'd0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("ctrl_start_timeout", int'(n < 40), 1);
  endtask

  // Requests issued while the downstream block is mid-sequence
  task automatic busy_reqs(int k, int s0, int s1, int s2);
    int s[3];
    int pend;
    s[0] = s0;
    s[1] = s1;
    s[2] = s2;
    pend = -1;
    chk("busy_high", int'(seq_busy), 1);
    for (int i = 0; i < k; i++) begin
      if (s[i] >= NP) err_cnt++;
      else pend = s[i];
      @(negedge clock);
      rate_sel = 3'(s[i]);
      rate_valid = 1'b1;
    end
    @(negedge clock);
    rate_valid = 1'b0;
`ifdef RECONF_PENDING_EN
    if (pend >= 0) model_idle(pend, 1'b0);
`else
    if (pend >= 0) pend = -1;
`endif
  endtask

  task automatic drain();
    int n = 0;
    while ((want_q.size() != 0 || done_rom_q.size() != 0 || err_cnt != 0)
           && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("drain_timeout", int'(n < 400), 1);
    want_q.delete();
    done_rom_q.delete();
    done_lerr_q.delete();
    err_cnt = 0;
    repeat (4) @(negedge clock);
    chk("idle_busy_low", int'(seq_busy), 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_want"}, int'(want_to_reconfig), 0);
    chk({tag, "_intended"}, int'(intended_rom), 0);
    chk({tag, "_active"}, int'(active_rom), 0);
    chk({tag, "_busy"}, int'(seq_busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err_range), 0);
    chk({tag, "_lock_err"}, int'(lock_err), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int main_sel;
    bit nl;
    bit reconf;
    reset_n = 1'b1;
    rate_sel = 3'd0;
    rate_valid = 1'b0;
    ctrl_state = 3'd0;
    pll_locked = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic reconfiguration to profile 3
    model_idle(3, 1'b0);
    send(3);
    drain();
    chk("basic_active", int'(active_rom), 3);
    chk("basic_lock_err", int'(lock_err), 0);

    // Out-of-range request while idle
    model_idle(6, 1'b0);
    send(6);
    chk("oor_err_pulse", int'(err_range), 1);
    chk("oor_busy", int'(seq_busy), 0);
    drain();

    // Same profile as active: immediate done
    model_idle(3, 1'b0);
    send(3);
    chk("same_done_pulse", int'(done), 1);
    chk("same_no_want", int'(want_to_reconfig), 0);
    drain();

    // Lock timeout, then a clean reconfig clears the flag
    model_idle(1, 1'b1);
    send(1);
    drain();
    chk("timeout_lock_err", int'(lock_err), 1);
    chk("timeout_active", int'(active_rom), 1);
    model_idle(2, 1'b0);
    send(2);
    drain();
    chk("recover_lock_err", int'(lock_err), 0);
    chk("recover_active", int'(active_rom), 2);

    // Two in-range requests and one out-of-range while busy
    main_sel = (m_active == 1) ? 0 : 1;
    model_idle(main_sel, 1'b0);
    send(main_sel);
    wait_ctrl();
    busy_reqs(3, 2, 7, 4);
    drain();
    chk("pending_active", int'(active_rom), m_active);

    // Reset while waiting for the control block to go idle
    main_sel = (m_active == 4) ? 3 : 4;
    model_idle(main_sel, 1'b0);
    send(main_sel);
    wait_ctrl();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    want_q.delete();
    done_rom_q.delete();
    done_lerr_q.delete();
    nolock_q.delete();
    err_cnt = 0;
    m_active = 0;
    m_lerr = 0;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    drain();

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 7);
      nl = ($urandom_range(0, 3) == 0);
      reconf = (sel < NP) && (sel != m_active);
      model_idle(sel, nl);
      send(sel);
      if (reconf && $urandom_range(0, 1) == 1) begin
        wait_ctrl();
        busy_reqs($urandom_range(1, 3), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
      end
      drain();
      chk("rand_active", int'(active_rom), m_active);
      chk("rand_lock_err", int'(lock_err), m_lerr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reconfig_req_seq.md
RECONFIG_REQ_SEQ -- requirements
Module: reconfig_req_seq

Interface
REQ-001 SHALL have parameter NUM_PROFILES, default 5: number of valid ROM profile indices, 0..NUM_PROFILES-1.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum number of cycles to wait for PLL lock after reconfiguration.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rate_sel  input  3  requested profile index; sampled only when rate_valid=1.
REQ-006 SHALL have port rate_valid  input  1  single-cycle request strobe.
REQ-007 SHALL have port ctrl_state  input  3  current state of the downstream reconfig control state machine; 0 = idle.
REQ-008 SHALL have port pll_locked  input  1  PLL lock, asynchronous to clock.
REQ-009 SHALL have port want_to_reconfig  output  1  single-cycle reconfig request to the downstream control block.
REQ-010 SHALL have port intended_rom  output  3  profile index presented with want_to_reconfig.
REQ-011 SHALL have port active_rom  output  3  profile of the last completed reconfiguration.
REQ-012 SHALL have port seq_busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port done  output  1  single-cycle completion pulse.
REQ-014 SHALL have port err_range  output  1  single-cycle pulse: request index >= NUM_PROFILES.
REQ-015 SHALL have port lock_err  output  1  sticky flag: lock timeout occurred.

Function
REQ-016 SHALL pass pll_locked through a 2-flop synchronizer; all use of lock refers to the synchronized value.
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT_START, WAIT_CTRL_IDLE, WAIT_LOCK.
REQ-018 IDLE with rate_valid=1 and rate_sel>=NUM_PROFILES: SHALL pulse err_range on the next cycle and stay in IDLE.
REQ-019 IDLE with rate_valid=1 and rate_sel==active_rom: SHALL pulse done on the next cycle, issue no reconfig and stay in IDLE.
REQ-020 IDLE with any other valid request: SHALL latch rate_sel into intended_rom and go to ISSUE.
REQ-021 ISSUE: SHALL wait until ctrl_state==0, then assert want_to_reconfig for exactly one cycle and go to WAIT_START.
REQ-022 intended_rom SHALL be held stable from ISSUE until the sequencer returns to IDLE.
REQ-023 WAIT_START: ctrl_state!=0 SHALL go to WAIT_CTRL_IDLE.
REQ-024 WAIT_CTRL_IDLE: ctrl_state==0 SHALL clear the lock counter and go to WAIT_LOCK.
REQ-025 WAIT_LOCK on synced lock=1: SHALL set active_rom=intended_rom, clear lock_err, pulse done, and go to IDLE.
REQ-026 WAIT_LOCK: the 16-bit counter SHALL increment each cycle.
REQ-027 WAIT_LOCK when counter==LOCK_TIMEOUT without lock: SHALL set lock_err, set active_rom=intended_rom, pulse done, and go to IDLE.
REQ-028 Out-of-range requests arriving while seq_busy=1 SHALL pulse err_range and SHALL NOT affect the sequence in progress.
REQ-029 Simultaneous lock and timeout in the same cycle: lock SHALL win, so lock_err stays clear.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE and all outputs to 0 (active_rom=0, intended_rom=0, lock_err=0).
REQ-031 reset_n=0 SHALL also clear the counter, the synchronizer flops and the pending register.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence without a done pulse.

Configuration
REQ-033 Macro RECONF_PENDING_EN defined: in-range requests while seq_busy=1 SHALL be stored in a one-deep pending register, where the latest request overwrites any earlier one.
REQ-034 With RECONF_PENDING_EN defined, the pending request SHALL be processed as a fresh IDLE request (per REQ-018..020) on the cycle after the sequencer returns to IDLE.
REQ-035 Macro RECONF_PENDING_EN undefined: in-range requests while seq_busy=1 SHALL be dropped silently.

Verification
REQ-036 Reset, then rate_sel=3 with rate_valid, control model cycles ctrl_state 0->1..6->0, lock after 10 cycles -> exactly one want_to_reconfig with intended_rom=3; done pulse; active_rom=3.
REQ-037 rate_sel=6 with rate_valid (NUM_PROFILES=5) -> err_range pulse; no want_to_reconfig; seq_busy stays 0.
REQ-038 active_rom=3, then rate_sel=3 with rate_valid -> done on next cycle; no want_to_reconfig.
REQ-039 LOCK_TIMEOUT=20, lock held low -> done after timeout, lock_err=1; next successful reconfig clears lock_err.
REQ-040 With RECONF_PENDING_EN: requests 2 then 4 during a busy sequence -> after completion, a single reconfig to 4; without the macro, no second reconfig.
REQ-041 reset_n=0 during WAIT_CTRL_IDLE -> all outputs 0 immediately; no done pulse.
